// File: rtl/bram_arb_pkg.sv
// Shared types for the round-robin BRAM arbiter: response-tracking slot and
// arbitration state.
package bram_arb_pkg;

    // Slot index is sized for the largest supported requester count (8).
    localparam int ARB_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [ARB_IDX_W-1:0] idx;
    } rsp_slot_t;

    typedef enum logic {
        ARB_RR,
        ARB_LOCKED
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index and whether anything was picked.
module rr_priority_select #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        // Rotating the doubled vector puts the pointer at bit 0, so the lowest
        // set bit is the distance to the winner.
        rot = {req, req} >> ptr;
        any = 1'b0;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                off = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= NV) ? IW'(sum - NV) : sum[IW-1:0];
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/axi_lite_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between NumReq requesters,
// with an optional per-requester lock and fixed-latency response routing.
module axi_lite_bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NumReq          = 2,
    parameter int DataWidth       = 64,
    parameter int BRAM_ADDR_WIDTH = 12,
    parameter int ReadLatency     = 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NumReq-1:0]                             req_valid_i,
    output logic [NumReq-1:0]                             req_ready_o,
    input  logic [NumReq-1:0]                             req_lock_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]            req_we_i,
    input  logic [NumReq-1:0][BRAM_ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]              req_wrdata_i,
    output logic [NumReq-1:0]                             rsp_valid_o,
    output logic [DataWidth-1:0]                          rsp_rddata_o,
    output logic                                          bram_en,
    output logic [DataWidth/8-1:0]                        bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]                    bram_addr,
    output logic [DataWidth-1:0]                          bram_wrdata,
    input  logic [DataWidth-1:0]                          bram_rddata
);

    localparam int IW = idx_width(NumReq);

    arb_state_e          state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       prio_ptr;
    logic [NumReq-1:0]   elig;
    logic [NumReq-1:0]   gnt;
    logic [IW-1:0]       sel_ptr;
    logic [IW-1:0]       win;
    logic [IW-1:0]       next_ptr;
    logic                any;
    rsp_slot_t           pipe [ReadLatency];

    // While locked only the owner is eligible, even if it is idle this cycle.
    always_comb begin
        elig    = '0;
        sel_ptr = prio_ptr;
        if (!rst_i) begin
            if (state == ARB_LOCKED) begin
                elig    = req_valid_i & (NumReq'(1) << owner);
                sel_ptr = owner;
            end else begin
                elig = req_valid_i;
            end
        end
    end

    rr_priority_select #(
        .N  (NumReq),
        .IW (IW)
    ) u_sel (
        .req (elig),
        .ptr (sel_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign req_ready_o = gnt;
    assign bram_en     = any;
    assign bram_we     = any ? req_we_i[win]     : '0;
    assign bram_addr   = any ? req_addr_i[win]   : '0;
    assign bram_wrdata = any ? req_wrdata_i[win] : '0;
    assign next_ptr    = (win == IW'(NumReq - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB_RR;
            owner    <= '0;
            prio_ptr <= '0;
        end else if (any) begin
            prio_ptr <= next_ptr;
            if (req_lock_i[win]) begin
                state <= ARB_LOCKED;
                owner <= win;
            end else begin
                state <= ARB_RR;
            end
        end
    end

    // One slot per cycle of BRAM latency; the tail slot names the requester
    // whose data is on bram_rddata right now.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < ReadLatency; k++) pipe[k] <= '0;
        end else begin
            pipe[0].valid <= any;
            pipe[0].idx   <= ARB_IDX_W'(win);
            for (int k = 1; k < ReadLatency; k++) pipe[k] <= pipe[k-1];
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (pipe[ReadLatency-1].valid)
            rsp_valid_o = NumReq'(1) << pipe[ReadLatency-1].idx;
    end

    assign rsp_rddata_o = bram_rddata;

endmodule

// File: tb/tb_axi_lite_bram_arbiter.sv
// Bench for axi_lite_bram_arbiter: two instances (ReadLatency 1 and 3) share
// stimulus and are compared against an abstract arbitration/memory model.
module tb_axi_lite_bram_arbiter;

    localparam int NR = 2;
    localparam int DW = 64;
    localparam int AW = 12;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]         valid, lock;
    logic [NR-1:0][BW-1:0] we;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][DW-1:0] wd;

    logic [NR-1:0] rdy1, rv1, rdy3, rv3;
    logic [DW-1:0] rd1, rd3, b1_wd, b3_wd, b1_rd, b3_rd;
    logic          b1_en, b3_en;
    logic [BW-1:0] b1_we, b3_we;
    logic [AW-1:0] b1_addr, b3_addr;

    axi_lite_bram_arbiter #(.NumReq(NR), .DataWidth(DW), .BRAM_ADDR_WIDTH(AW), .ReadLatency(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy1), .req_lock_i(lock),
        .req_we_i(we), .req_addr_i(addr), .req_wrdata_i(wd), .rsp_valid_o(rv1), .rsp_rddata_o(rd1),
        .bram_en(b1_en), .bram_we(b1_we), .bram_addr(b1_addr), .bram_wrdata(b1_wd), .bram_rddata(b1_rd));

    axi_lite_bram_arbiter #(.NumReq(NR), .DataWidth(DW), .BRAM_ADDR_WIDTH(AW), .ReadLatency(3)) u3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy3), .req_lock_i(lock),
        .req_we_i(we), .req_addr_i(addr), .req_wrdata_i(wd), .rsp_valid_o(rv3), .rsp_rddata_o(rd3),
        .bram_en(b3_en), .bram_we(b3_we), .bram_addr(b3_addr), .bram_wrdata(b3_wd), .bram_rddata(b3_rd));

    // BRAM macros with 1 and 3 cycles of read latency
    logic [DW-1:0] mem1 [1<<AW];
    logic [DW-1:0] mem3 [1<<AW];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];

    always @(posedge clk) begin
        if (b1_en) begin
            p1 <= mem1[b1_addr];
            for (int b = 0; b < BW; b++) if (b1_we[b]) mem1[b1_addr][8*b +: 8] <= b1_wd[8*b +: 8];
        end
    end
    always @(posedge clk) begin
        if (b3_en) begin
            p3[0] <= mem3[b3_addr];
            for (int b = 0; b < BW; b++) if (b3_we[b]) mem3[b3_addr][8*b +: 8] <= b3_wd[8*b +: 8];
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1_rd = p1;
    assign b3_rd = p3[2];

    // Observation of latency-1 responses for directed checks
    int            pc [NR];
    logic [DW-1:0] last_rd0, last_rd1;
    initial begin
        pc[0] = 0;
        pc[1] = 0;
    end
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (rv1[i]) pc[i] = pc[i] + 1;
        if (rv1[0]) last_rd0 = rd1;
        if (rv1[1]) last_rd1 = rd1;
    end

    // Reference model
    typedef struct {
        int          due;
        int          who;
        bit          rd;
        logic [63:0] data;
    } exp_t;

    logic [DW-1:0] refmem [1<<AW];
    exp_t q1[$], q3[$];
    int ptr, owner, cyc, last_gi;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ptr = 0;
        owner = -1;
        q1.delete();
        q3.delete();
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input logic [BW-1:0] w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid[i] = v;
        lock[i]  = lk;
        we[i]    = w;
        addr[i]  = a;
        wd[i]    = d;
    endtask

    task automatic rnd_req(input int i);
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) ? BW'($urandom) : '0,
                AW'($urandom_range(0, 15)), {$urandom, $urandom});
    endtask

    // One clock cycle: compare at the negedge, advance the model at the posedge.
    task automatic step();
        int gi;
        logic [NR-1:0] eg, erv;
        exp_t e;
        @(negedge clk);
        gi = -1;
        if (owner >= 0) begin
            if (valid[owner]) gi = owner;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int j = (ptr + k) % NR;
                if (gi < 0 && valid[j]) gi = j;
            end
        end
        eg = (gi >= 0) ? (NR'(1) << gi) : '0;
        check("ready_l1", rdy1, eg);
        check("ready_l3", rdy3, eg);
        check("bram_en", b1_en, gi >= 0);
        check("bram_we", b1_we, (gi >= 0) ? we[gi] : '0);
        check("bram_addr", b1_addr, (gi >= 0) ? addr[gi] : '0);
        check("bram_wrdata", b1_wd, (gi >= 0) ? wd[gi] : '0);
        check("bram_addr_l3", b3_addr, (gi >= 0) ? addr[gi] : '0);

        erv = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            erv = NR'(1) << e.who;
            if (e.rd) check("rsp_data_l1", rd1, e.data);
        end
        check("rsp_valid_l1", rv1, erv);
        erv = '0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e = q3.pop_front();
            erv = NR'(1) << e.who;
            if (e.rd) check("rsp_data_l3", rd3, e.data);
        end
        check("rsp_valid_l3", rv3, erv);

        @(posedge clk);
        last_gi = gi;
        if (gi >= 0) begin
            e.who  = gi;
            e.rd   = (we[gi] == '0);
            e.data = refmem[addr[gi]];
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 3;
            q3.push_back(e);
            for (int b = 0; b < BW; b++)
                if (we[gi][b]) refmem[addr[gi]][8*b +: 8] = wd[gi][8*b +: 8];
            ptr   = (gi + 1) % NR;
            owner = lock[gi] ? gi : -1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        valid = '0;
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready1"}, rdy1, '0);
        check({tag, "_ready3"}, rdy3, '0);
        check({tag, "_rv1"}, rv1, '0);
        check({tag, "_rv3"}, rv3, '0);
        check({tag, "_en"}, {b1_en, b3_en}, '0);
        check({tag, "_we"}, b1_we, '0);
        check({tag, "_addr"}, b1_addr, '0);
        check({tag, "_wd"}, b1_wd, '0);
        check({tag, "_rdpass"}, rd3, b3_rd);
    endtask

    int g [6];
    int base0, base1;

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem1[a] = '0;
            mem3[a] = '0;
            refmem[a] = '0;
        end
        p1 = '0;
        for (int k = 0; k < 3; k++) p3[k] = '0;
        valid = '0; lock = '0; we = '0; addr = '0; wd = '0;
        cyc = 0;
        last_gi = -1;
        model_reset();

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin: both reading for six cycles
        base0 = pc[0];
        base1 = pc[1];
        set_req(0, 1, 0, '0, 12'h001, '0);
        set_req(1, 1, 0, '0, 12'h002, '0);
        for (int k = 0; k < 6; k++) begin
            step();
            g[k] = last_gi;
        end
        idle(4);
        for (int k = 0; k < 6; k++) check("rr_order", g[k], k % 2);
        check("rr_pulses0", pc[0] - base0, 3);
        check("rr_pulses1", pc[1] - base1, 3);

        // Read routing
        set_req(0, 1, 0, 8'hFF, 12'h010, 64'hDEADBEEF);
        step();
        valid[0] = 1'b0;
        set_req(1, 1, 0, '0, 12'h010, '0);
        step();
        idle(4);
        check("route_data", last_rd1, 64'hDEADBEEF);

        // Lock: owner idle for a cycle must still block requester 1
        set_req(1, 1, 0, '0, 12'h005, '0);
        set_req(0, 1, 1, '0, 12'h020, '0);
        step();
        check("lock_g0", last_gi, 0);
        valid[0] = 1'b0;
        step();
        check("lock_hold", last_gi, -1);
        set_req(0, 1, 0, 8'hFF, 12'h020, 64'h0123456789ABCDEF);
        step();
        check("lock_release", last_gi, 0);
        valid[0] = 1'b0;
        step();
        check("lock_after", last_gi, 1);
        idle(4);

        // Back-to-back reads 0,1,0 (latency-3 timing via the model queues)
        set_req(0, 1, 0, '0, 12'h010, '0);
        set_req(1, 1, 0, '0, 12'h020, '0);
        step();
        check("b2b_0", last_gi, 0);
        step();
        check("b2b_1", last_gi, 1);
        valid[1] = 1'b0;
        step();
        check("b2b_2", last_gi, 0);
        idle(5);

        // Byte enables
        set_req(0, 1, 0, 8'hFF, 12'h030, '1);
        step();
        set_req(0, 1, 0, 8'h0F, 12'h030, 64'h1122334455667788);
        step();
        set_req(0, 1, 0, '0, 12'h030, '0);
        step();
        idle(4);
        check("byte_en", last_rd0, 64'hFFFFFFFF55667788);

        // Random traffic with a reset in the middle
        rnd_req(0);
        rnd_req(1);
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("mid");
                set_req(0, 1, 0, '0, 12'h003, '0);
                set_req(1, 1, 0, '0, 12'h004, '0);
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
                step();
                check("post_rst_grant", last_gi, 0);
            end else begin
                step();
            end
            for (int i = 0; i < NR; i++)
                if (!valid[i] || last_gi == i) rnd_req(i);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
